// File: rtl/lcd_instruction_arbiter.sv
// Shares the single LCD_controller instruction port between NUM_REQ requesters.
// Replays the LCD init table after reset, then grants round-robin with optional burst locking.
module lcd_instruction_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 18'h3FFFF + 1024
) (
  input  logic                   Clock_50,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     Req_valid,
  input  logic [9*NUM_REQ-1:0]   Req_instruction,
  input  logic [NUM_REQ-1:0]     Req_lock,
  output logic [NUM_REQ-1:0]     Req_accept,
  output logic [NUM_REQ-1:0]     Req_done,
  output logic [NUM_REQ-1:0]     Grant,
  output logic                   Init_done,
  output logic                   Timeout_error,
  output logic                   LCD_start,
  output logic [8:0]             LCD_instruction,
  input  logic                   LCD_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_INIT_ISSUE,
    S_INIT_WAIT,
    S_IDLE,
    S_WAIT_DONE
  } state_t;

  state_t               state_q;
  logic [2:0]           init_idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     own_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 first_q;
  logic [NUM_REQ-1:0]   accept_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 init_done_q;
  logic                 timeout_q;
  logic                 start_q;
  logic [8:0]           instr_q;

  logic [IDX_W-1:0]     cand;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic                 lock_hold;
  logic                 issue_en;
  logic [IDX_W-1:0]     issue_idx;
  logic [IDX_W-1:0]     ptr_d;
  logic                 lcd_seen;
  logic                 cnt_hit;
  logic                 wait_end;

  function automatic logic [8:0] init_code(input logic [2:0] i);
    case (i)
      3'd0:    init_code = 9'h038;
      3'd1:    init_code = 9'h00C;
      3'd2:    init_code = 9'h001;
      3'd3:    init_code = 9'h006;
      default: init_code = 9'h080;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + IDX_W'(1);
  endfunction

  // Round-robin search starting at the pointer; first valid requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_vld && Req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // A kept grant with its lock still high restricts eligibility to the owner.
  assign lock_hold = (grant_q != '0) && Req_lock[own_q];
  assign issue_en  = (state_q == S_IDLE) && (lock_hold ? Req_valid[own_q] : pick_vld);
  assign issue_idx = lock_hold ? own_q : pick_idx;
  assign ptr_d     = next_idx(issue_idx);

  // LCD_done is ignored in the start cycle; the counter forces completion otherwise.
  assign lcd_seen  = LCD_done && !first_q;
  assign cnt_hit   = (cnt_q == CNT_LAST);
  assign wait_end  = lcd_seen || cnt_hit;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q     <= S_INIT_ISSUE;
      init_idx_q  <= '0;
      ptr_q       <= '0;
      own_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      accept_q    <= '0;
      done_q      <= '0;
      grant_q     <= '0;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      start_q     <= 1'b0;
      instr_q     <= '0;
    end else begin
      start_q  <= 1'b0;
      accept_q <= '0;
      done_q   <= '0;
      case (state_q)
        S_INIT_ISSUE: begin
          instr_q <= init_code(init_idx_q);
          start_q <= 1'b1;
          cnt_q   <= '0;
          first_q <= 1'b1;
          state_q <= S_INIT_WAIT;
        end

        S_INIT_WAIT: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (wait_end) begin
            if (!lcd_seen) timeout_q <= 1'b1;
            if (init_idx_q < 3'd4) begin
              init_idx_q <= init_idx_q + 3'd1;
              state_q    <= S_INIT_ISSUE;
            end else begin
              init_done_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end

        S_IDLE: begin
          if (issue_en) begin
            grant_q  <= onehot(issue_idx);
            accept_q <= onehot(issue_idx);
            own_q    <= issue_idx;
            ptr_q    <= ptr_d;
            instr_q  <= Req_instruction[9*issue_idx +: 9];
            start_q  <= 1'b1;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            state_q  <= S_WAIT_DONE;
          end else if (!lock_hold) begin
            grant_q <= '0;
          end
        end

        S_WAIT_DONE: begin
          first_q <= 1'b0;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (wait_end) begin
            if (!lcd_seen) timeout_q <= 1'b1;
            done_q <= onehot(own_q);
            if (!Req_lock[own_q]) grant_q <= '0;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_INIT_ISSUE;
      endcase
    end
  end

  assign Req_accept      = accept_q;
  assign Req_done        = done_q;
  assign Grant           = grant_q;
  assign Init_done       = init_done_q;
  assign Timeout_error   = timeout_q;
  assign LCD_start       = start_q;
  assign LCD_instruction = instr_q;

endmodule

// File: tb/tb_lcd_instruction_arbiter.sv
// Bench for lcd_instruction_arbiter: vector table, lock/timeout/reset sequences and random traffic
// checked against a transaction-level round-robin model with an LCD_done responder.
module tb_lcd_instruction_arbiter;
  localparam int N = 2;
  localparam int T = 40;

  logic         Clock_50 = 1'b0;
  logic         Reset = 1'b1;
  logic [1:0]   Req_valid = '0;
  logic [17:0]  Req_instruction = '0;
  logic [1:0]   Req_lock = '0;
  logic [1:0]   Req_accept, Req_done, Grant;
  logic         Init_done, Timeout_error, LCD_start;
  logic [8:0]   LCD_instruction;
  logic         LCD_done = 1'b0;

  lcd_instruction_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
    .Clock_50(Clock_50), .Reset(Reset), .Req_valid(Req_valid),
    .Req_instruction(Req_instruction), .Req_lock(Req_lock),
    .Req_accept(Req_accept), .Req_done(Req_done), .Grant(Grant),
    .Init_done(Init_done), .Timeout_error(Timeout_error),
    .LCD_start(LCD_start), .LCD_instruction(LCD_instruction), .LCD_done(LCD_done)
  );

  always #10 Clock_50 = ~Clock_50;

  typedef struct {
    logic [1:0] v;
    logic [8:0] i0;
    logic [8:0] i1;
    int         exp_idx;
    logic [8:0] exp_instr;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  int cd = 0, resp_delay = 20, exp_done = 0, last_start = -100;
  bit resp_never = 0, resp_rand = 0, chk_rr = 1, outst = 0;
  int ptr_m = 0, own_m = 0, acc1_cnt = 0;
  logic [1:0]  prev_valid;
  logic [17:0] prev_instr;
  logic [8:0]  init_tab [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] v);
    for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  // One clock: sample outputs after the edge, apply model rules, drive the LCD_done responder.
  task automatic tick();
    int idx, d;
    prev_valid = Req_valid;
    prev_instr = Req_instruction;
    @(posedge Clock_50);
    #1;
    cyc++;
    if (Req_accept != 0 || Req_done != 0) begin
      chk("accept_onehot0", 32'($onehot0(Req_accept)), 1);
      chk("done_onehot0", 32'($onehot0(Req_done)), 1);
    end
    if (LCD_start) begin
      chk("start_gap", 32'((cyc - last_start) >= 3), 1);
      chk("start_has_accept", 32'(|Req_accept), 32'(Init_done));
      last_start = cyc;
    end
    if (Req_done != 0) begin
      chk("done_owner", 32'(Req_done), outst ? (1 << own_m) : 0);
      chk("done_cycle", cyc, exp_done);
      outst = 0;
    end
    if (Req_accept != 0) begin
      idx = Req_accept[1] ? 1 : 0;
      if (chk_rr) chk("rr_order", idx, rr_pick(prev_valid));
      chk("accept_was_valid", 32'(prev_valid[idx]), 1);
      chk("issued_instr", 32'(LCD_instruction), 32'(prev_instr[9*idx +: 9]));
      chk("grant_eq_accept", 32'(Grant), 32'(Req_accept));
      chk("no_overlap", 32'(outst), 0);
      outst = 1;
      own_m = idx;
      ptr_m = (idx + 1) % N;
      if (idx == 1) acc1_cnt++;
    end
    LCD_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) LCD_done = 1'b1;
    end
    if (LCD_start) begin
      if (resp_never) exp_done = cyc + T;
      else begin
        d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
        cd = d;
        exp_done = cyc + d + 1;
        if (resp_rand && $urandom_range(0, 3) == 0) LCD_done = 1'b1;
      end
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 32'({Req_accept, Req_done, Grant, Init_done, Timeout_error, LCD_start, LCD_instruction}), 0);
  endtask

  task automatic wait_accept(output int idx, output int at);
    int n = 0;
    idx = -1;
    at  = -1;
    while (n < 300) begin
      tick();
      n++;
      if (Req_accept != 0) begin
        idx = Req_accept[1] ? 1 : 0;
        at  = cyc;
        break;
      end
    end
    if (idx < 0) chk("accept_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outst && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", 32'(outst), 0);
  endtask

  task automatic run_init();
    int k = 0, n = 0;
    while (!Init_done && n < 400) begin
      tick();
      n++;
      if (LCD_start) begin
        if (k < 5) chk("init_instr", 32'(LCD_instruction), 32'(init_tab[k]));
        k++;
      end
    end
    chk("init_done", 32'(Init_done), 1);
    chk("init_starts", k, 5);
    chk("init_grant", 32'(Grant), 0);
  endtask

  initial begin
    vec_t tab [9];
    int idx, at, lcyc;
    int sent [2], gap [2];
    bit pend [2];

    tab[0] = '{2'b11, 9'h1A1, 9'h1B2, 0, 9'h1A1};
    tab[1] = '{2'b11, 9'h1A1, 9'h1B2, 1, 9'h1B2};
    tab[2] = '{2'b11, 9'h1A1, 9'h1B2, 0, 9'h1A1};
    tab[3] = '{2'b10, 9'h1A1, 9'h1B2, 1, 9'h1B2};
    tab[4] = '{2'b10, 9'h1A1, 9'h155, 1, 9'h155};
    tab[5] = '{2'b01, 9'h0AA, 9'h155, 0, 9'h0AA};
    tab[6] = '{2'b11, 9'h1FF, 9'h100, 1, 9'h100};
    tab[7] = '{2'b11, 9'h1FF, 9'h100, 0, 9'h1FF};
    tab[8] = '{2'b10, 9'h1FF, 9'h100, 1, 9'h100};

    // Power-on reset and init replay
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("reset_outputs");
    end
    Reset = 1'b0;
    run_init();

    // Vector table: alternation, skip, wrap
    for (int r = 0; r < 9; r++) begin
      Req_valid = tab[r].v;
      Req_instruction = {tab[r].i1, tab[r].i0};
      wait_accept(idx, at);
      chk("vec_idx", idx, tab[r].exp_idx);
      chk("vec_instr", 32'(LCD_instruction), 32'(tab[r].exp_instr));
    end
    Req_valid = '0;
    wait_idle();
    tick();
    chk("grant_released", 32'(Grant), 0);

    // Locked burst: 0C0 plus 16 data bytes from requester 0
    acc1_cnt = 0;
    Req_lock = 2'b01;
    Req_valid = 2'b01;
    Req_instruction[8:0] = 9'h0C0;
    wait_accept(idx, at);
    chk("lock_first_idx", idx, 0);
    chk_rr = 0;
    Req_valid = 2'b11;
    Req_instruction[17:9] = 9'h1EE;
    for (int k = 0; k < 16; k++) begin
      Req_instruction[8:0] = 9'(9'h141 + k);
      wait_accept(idx, at);
      chk("lock_idx", idx, 0);
      chk("lock_instr", 32'(LCD_instruction), 32'(9'h141 + k));
    end
    Req_valid = 2'b10;
    wait_idle();
    chk("lock_grant_kept", 32'(Grant), 1);
    for (int k = 0; k < 3; k++) tick();
    chk("lock_grant_still", 32'(Grant), 1);
    chk("lock_no_req1", acc1_cnt, 0);
    Req_lock = 2'b00;
    chk_rr = 1;
    lcyc = cyc;
    wait_accept(idx, at);
    chk("unlock_idx", idx, 1);
    chk("unlock_latency_ok", 32'((at - lcyc) <= 2), 1);
    Req_valid = '0;
    wait_idle();

    // LCD_done never arrives: forced completion, sticky error, next request served
    resp_never = 1;
    Req_valid = 2'b01;
    Req_instruction = {9'h122, 9'h111};
    wait_accept(idx, at);
    chk("to_first_idx", idx, 0);
    Req_valid = 2'b10;
    while (cyc < at + T - 1) tick();
    chk("to_err_before", 32'(Timeout_error), 0);
    chk("to_done_before", 32'(Req_done), 0);
    tick();
    chk("to_done", 32'(Req_done), 1);
    chk("to_err", 32'(Timeout_error), 1);
    resp_never = 0;
    tick();
    chk("to_next_accept", 32'(Req_accept), 2);
    Req_valid = '0;
    wait_idle();
    chk("to_sticky", 32'(Timeout_error), 1);

    // Reset five cycles into a wait, with requests pending through init
    Req_valid = 2'b01;
    Req_instruction = {9'h1B2, 9'h133};
    wait_accept(idx, at);
    for (int k = 0; k < 4; k++) tick();
    Reset = 1'b1;
    cd = 0;
    outst = 0;
    ptr_m = 0;
    Req_valid = 2'b11;
    Req_instruction = {9'h1B2, 9'h1A1};
    tick();
    chk_zero("midreset_outputs");
    Reset = 1'b0;
    run_init();
    wait_accept(idx, at);
    chk("post_init_first_idx", idx, 0);
    Req_valid = 2'b10;
    wait_accept(idx, at);
    chk("post_init_second_idx", idx, 1);
    Req_valid = '0;
    wait_idle();

    // Random traffic with random LCD latency and spurious start-cycle LCD_done
    resp_rand = 1;
    for (int i = 0; i < 2; i++) begin
      sent[i] = 0;
      gap[i] = 0;
      pend[i] = 0;
    end
    for (int c = 0; c < 3000 && (sent[0] < 8 || sent[1] < 8 || outst); c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (Req_accept[i]) begin
          pend[i] = 0;
          sent[i]++;
          gap[i] = $urandom_range(0, 4);
        end else if (!pend[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (sent[i] < 8) begin
            pend[i] = 1;
            Req_instruction[9*i +: 9] = 9'($urandom);
          end
        end
      end
      Req_valid = {pend[1], pend[0]};
    end
    chk("rand_sent0", sent[0], 8);
    chk("rand_sent1", sent[1], 8);
    chk("rand_idle", 32'(outst), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
